vga_text_console: RTL and testbench

//  Character-stream front end for the VGA text generator's write port. Accepts one

---
 rtl/vga_text_pkg.sv | 34 +++
 rtl/vga_text_console_if.sv | 12 +
 rtl/vga_text_cursor.sv | 57 +++++
 rtl/vga_text_console.sv | 215 +++++++++++++++++++++
 tb/tb_vga_text_console.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants, control codes and sequencer state type
// for the 40x20 VGA text console front end.
package vga_text_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 20;
    localparam int TEXT_DEPTH = COLS * ROWS;
    localparam int RD_LAT     = 1;

    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = 10;
    localparam int LAT_W  = 2;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEXT_DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_CLR,
        ST_CLR
    } console_state_t;

endpackage

// File: rtl/vga_text_console_if.sv
// Character command handshake: cmd_valid/cmd_char from the requester,
// cmd_ready back from the console. master = requester, slave = console.
interface vga_text_console_if;

    logic       cmd_valid;
    logic [7:0] cmd_char;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_char, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_char, output cmd_ready);

endinterface

// File: rtl/vga_text_cursor.sv
// Cursor column/row register with move/home controls.
// Ports: clk, rst, i_inc/i_dec/i_nl/i_home_col/i_home/i_last_row in;
// o_col, o_row, o_addr (row*COLS+col), o_at_last_col/o_at_last_row/o_at_origin out.
module vga_text_cursor
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_nl,
    input  logic              i_home_col,
    input  logic              i_home,
    input  logic              i_last_row,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_last_col,
    output logic              o_at_last_row,
    output logic              o_at_origin
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign o_col         = r_col;
    assign o_row         = r_row;
    assign o_at_last_col = (r_col == COL_W'(COLS - 1));
    assign o_at_last_row = (r_row == ROW_W'(ROWS - 1));
    assign o_at_origin   = (r_col == '0) && (r_row == '0);
    assign o_addr        = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (rst || i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (i_home_col)
                r_col <= '0;
            else if (i_inc)
                r_col <= o_at_last_col ? '0 : r_col + 1'b1;
            else if (i_dec)
                r_col <= (r_col == '0) ? COL_W'(COLS - 1) : r_col - 1'b1;

            // Row never leaves 0..ROWS-1; overflow is handled by scrolling.
            if (i_last_row)
                r_row <= ROW_W'(ROWS - 1);
            else if (i_nl && !o_at_last_row)
                r_row <= r_row + 1'b1;
            else if (i_inc && o_at_last_col && !o_at_last_row)
                r_row <= r_row + 1'b1;
            else if (i_dec && (r_col == '0) && (r_row != '0))
                r_row <= r_row - 1'b1;
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// Character-stream front end and sole writer of the 40x20 text RAM.
// Ports: clk, rst, cmd (handshake slave), busy, cur_col, cur_row, ram_addr/wdata/we out, ram_rdata in.
module vga_text_console
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    vga_text_console_if.slave cmd,
    output logic              busy,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    console_state_t    r_state;
    console_state_t    w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [LAT_W-1:0]  r_lat;
    logic [7:0]        r_wdata;
    logic              r_is_bs;

    logic              w_idle;
    logic              w_xfer;
    logic              w_is_bs;
    logic              w_is_lf;
    logic              w_is_ff;
    logic              w_is_cr;
    logic              w_idx_last;

    logic              w_inc;
    logic              w_dec;
    logic              w_nl;
    logic              w_home_col;
    logic              w_home;
    logic              w_last_row;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_at_last_col;
    logic              w_at_last_row;
    logic              w_at_origin;

    assign w_idle        = (r_state == ST_IDLE);
    assign cmd.cmd_ready = w_idle;
    assign busy          = !w_idle;
    assign w_xfer        = cmd.cmd_valid && w_idle;

    assign w_is_bs    = (cmd.cmd_char == CH_BS);
    assign w_is_lf    = (cmd.cmd_char == CH_LF);
    assign w_is_ff    = (cmd.cmd_char == CH_FF);
    assign w_is_cr    = (cmd.cmd_char == CH_CR);
    assign w_idx_last = (r_idx == LAST_ADDR);

    vga_text_cursor u_cursor (
        .clk           (clk),
        .rst           (rst),
        .i_inc         (w_inc),
        .i_dec         (w_dec),
        .i_nl          (w_nl),
        .i_home_col    (w_home_col),
        .i_home        (w_home),
        .i_last_row    (w_last_row),
        .o_col         (cur_col),
        .o_row         (cur_row),
        .o_addr        (w_cur_addr),
        .o_at_last_col (w_at_last_col),
        .o_at_last_row (w_at_last_row),
        .o_at_origin   (w_at_origin)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    unique case (1'b1)
                        w_is_ff: w_next = ST_CLR;
                        w_is_cr: w_next = ST_IDLE;
                        w_is_lf: w_next = w_at_last_row ? ST_SCR_RD : ST_IDLE;
                        w_is_bs: w_next = w_at_origin ? ST_IDLE : ST_PUT;
                        default: w_next = ST_PUT;
                    endcase
                end
            end
            ST_PUT: begin
                if (!r_is_bs && w_at_last_col && w_at_last_row)
                    w_next = ST_SCR_RD;
                else
                    w_next = ST_IDLE;
            end
            ST_SCR_RD: begin
                if (r_lat == LAT_LAST)
                    w_next = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                w_next = (r_idx == SCR_LAST) ? ST_SCR_CLR : ST_SCR_RD;
            end
            ST_SCR_CLR,
            ST_CLR: begin
                if (w_idx_last)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr   = w_cur_addr;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        w_nl       = 1'b0;
        w_home_col = 1'b0;
        w_home     = 1'b0;
        w_last_row = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    unique case (1'b1)
                        w_is_ff: begin end
                        w_is_cr: w_home_col = 1'b1;
                        w_is_lf: begin
                            w_home_col = 1'b1;
                            w_nl       = 1'b1;
                        end
                        w_is_bs: w_dec = !w_at_origin;
                        default: begin end
                    endcase
                end
            end
            ST_PUT: begin
                ram_we    = 1'b1;
                ram_wdata = r_wdata;
                // Wrapping off the last cell leaves the cursor at the start of
                // the last row; the scroll that follows makes that row blank.
                if (!r_is_bs) begin
                    if (w_at_last_col && w_at_last_row)
                        w_home_col = 1'b1;
                    else
                        w_inc = 1'b1;
                end
            end
            ST_SCR_RD: begin
                ram_addr = r_idx + ADDR_W'(COLS);
            end
            ST_SCR_WR: begin
                ram_addr  = r_idx;
                ram_wdata = ram_rdata;
                ram_we    = 1'b1;
            end
            ST_SCR_CLR: begin
                ram_addr  = r_idx;
                ram_wdata = BLANK;
                ram_we    = 1'b1;
                if (w_idx_last) begin
                    w_home_col = 1'b1;
                    w_last_row = 1'b1;
                end
            end
            ST_CLR: begin
                ram_addr  = r_idx;
                ram_wdata = BLANK;
                ram_we    = 1'b1;
                w_home    = w_idx_last;
            end
            default: begin end
        endcase
    end

    // SCR_WR running past SCR_LAST lands exactly on the first cell of the
    // last row, which is where SCR_CLR starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_lat   <= '0;
            r_wdata <= '0;
            r_is_bs <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    r_lat <= '0;
                    if (w_xfer) begin
                        r_wdata <= w_is_bs ? BLANK : cmd.cmd_char;
                        r_is_bs <= w_is_bs;
                    end
                end
                ST_PUT: begin
                    r_idx <= '0;
                end
                ST_SCR_RD: begin
                    r_lat <= (r_lat == LAT_LAST) ? '0 : r_lat + 1'b1;
                end
                ST_SCR_WR: begin
                    r_idx <= r_idx + 1'b1;
                end
                ST_SCR_CLR,
                ST_CLR: begin
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed testbench for vga_text_console with a registered-read text RAM.
// Prints one TB_RESULT summary line.
module tb_vga_text_console;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [5:0] cur_col;
    logic [4:0] cur_row;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata = 8'h00;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:799];
    logic [9:0] wr_addr_log [0:4095];
    logic [7:0] wr_dat_log  [0:4095];
    int         wr_total = 0;

    vga_text_console_if bus ();

    vga_text_console dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus),
        .busy      (busy),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_addr_log[wr_total[11:0]] <= ram_addr;
            wr_dat_log[wr_total[11:0]]  <= ram_wdata;
            wr_total <= wr_total + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_char  = c;
        while (!bus.cmd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000)
            chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 4000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 4000)
            chk("idle_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        int cyc;
        int w0;
        int errs;
        int idx;

        bus.cmd_valid = 1'b0;
        bus.cmd_char  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        w0 = wr_total;
        send(8'h41);
        send(8'h42);
        wait_idle(cyc);
        chk("ab_writes", 32'(wr_total - w0), 32'd2);
        chk("ab_addr0", 32'(wr_addr_log[w0[11:0]]), 32'd0);
        chk("ab_addr1", 32'(wr_addr_log[(w0 + 1) & 4095]), 32'd1);
        chk("ab_ram0", 32'(mem[0]), 32'h41);
        chk("ab_ram1", 32'(mem[1]), 32'h42);
        chk("ab_col", 32'(cur_col), 32'd2);
        chk("ab_row", 32'(cur_row), 32'd0);

        send(8'h0D);
        chk("cr_col", 32'(cur_col), 32'd0);
        for (int i = 0; i < 40; i++)
            send(8'h78);
        wait_idle(cyc);
        chk("x_ram0", 32'(mem[0]), 32'h78);
        chk("x_ram39", 32'(mem[39]), 32'h78);
        chk("x_col", 32'(cur_col), 32'd0);
        chk("x_row", 32'(cur_row), 32'd1);

        send(8'h0A);
        send(8'h0A);
        chk("lf_col", 32'(cur_col), 32'd0);
        chk("lf_row", 32'(cur_row), 32'd3);
        send(8'h08);
        wait_idle(cyc);
        chk("bs_col", 32'(cur_col), 32'd39);
        chk("bs_row", 32'(cur_row), 32'd2);
        chk("bs_ram119", 32'(mem[119]), 32'h20);

        w0 = wr_total;
        send(8'h0C);
        send(8'h51);
        wait_idle(cyc);
        chk("ff_writes", 32'(wr_total - w0), 32'd801);
        errs = 0;
        for (int k = 0; k < 800; k++) begin
            idx = (w0 + k) & 4095;
            if (wr_addr_log[idx] !== 10'(k) || wr_dat_log[idx] !== 8'h20)
                errs++;
        end
        chk("ff_order", 32'(errs), 32'd0);
        idx = (w0 + 800) & 4095;
        chk("held_addr", 32'(wr_addr_log[idx]), 32'd0);
        chk("held_data", 32'(wr_dat_log[idx]), 32'h51);
        chk("held_col", 32'(cur_col), 32'd1);
        chk("held_row", 32'(cur_row), 32'd0);
        chk("ff_ram799", 32'(mem[799]), 32'h20);

        send(8'h08);
        wait_idle(cyc);
        chk("bs1_col", 32'(cur_col), 32'd0);
        chk("bs1_ram0", 32'(mem[0]), 32'h20);
        w0 = wr_total;
        send(8'h08);
        repeat (3) @(negedge clk);
        chk("bs0_writes", 32'(wr_total - w0), 32'd0);
        chk("bs0_col", 32'(cur_col), 32'd0);
        chk("bs0_row", 32'(cur_row), 32'd0);
        chk("bs0_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 19; r++)
            for (int c = 0; c < 40; c++)
                send(8'(8'h61 + r));
        for (int c = 0; c < 5; c++)
            send(8'h74);
        wait_idle(cyc);
        chk("fill_col", 32'(cur_col), 32'd5);
        chk("fill_row", 32'(cur_row), 32'd19);
        send(8'h0A);
        wait_idle(cyc);
        chk("scr_cycles", 32'(cyc), 32'd1560);
        chk("scr_ram0", 32'(mem[0]), 32'h62);
        chk("scr_ram39", 32'(mem[39]), 32'h62);
        chk("scr_ram40", 32'(mem[40]), 32'h63);
        chk("scr_ram680", 32'(mem[680]), 32'h73);
        chk("scr_ram720", 32'(mem[720]), 32'h74);
        chk("scr_ram724", 32'(mem[724]), 32'h74);
        chk("scr_ram760", 32'(mem[760]), 32'h20);
        chk("scr_ram799", 32'(mem[799]), 32'h20);
        chk("scr_col", 32'(cur_col), 32'd0);
        chk("scr_row", 32'(cur_row), 32'd19);

        send(8'h0A);
        repeat (299) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_col", 32'(cur_col), 32'd0);
        chk("abort_row", 32'(cur_row), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        send(8'h5A);
        wait_idle(cyc);
        chk("z_ram0", 32'(mem[0]), 32'h5A);
        chk("z_col", 32'(cur_col), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
